div_unit: RTL
=============

Name: div_unit

Overview:
- Iterative radix-2 restoring divider for the execute stage, serving MIPS DIV and DIVU.
- Takes the forwarded execute-stage operands (rs value as dividend, rt value as divisor).
- Produces the 64-bit {remainder, quotient} word written into hilo_reg: hi = remainder, lo = quotient.
- Raises busy_o so the hazard unit can stall F/D/E until the result is ready.

Parameters:
- WIDTH, 32, operand width; result_o is 2*WIDTH.
- CNT_W, 6, iteration counter width; must hold the value WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- start_i  in  1  begin a divide; sampled only in IDLE.
- signed_i  in  1  1 = DIV (two's complement), 0 = DIVU; captured with start_i.
- annul_i  in  1  abort the operation in flight (flushE/exception); highest priority after reset.
- a_i  in  WIDTH  dividend.
- b_i  in  WIDTH  divisor.
- busy_o  out  1  high while in BUSY or ZERO.
- ready_o  out  1  one-cycle pulse: result_o is valid.
- result_o  out  2*WIDTH  {remainder[63:32], quotient[31:0]}.

Behaviour:
- Reset (rst=0, async): state=IDLE; busy_o=0, ready_o=0, result_o=0, counter=0, internal registers=0.
- States: IDLE, BUSY, ZERO, DONE.
- IDLE:
  - start_i=1 and b_i!=0 -> BUSY. Latch |a|, |b| (magnitudes when signed_i=1, raw values otherwise). Latch quotient sign = a[31]^b[31] and remainder sign = a[31] (both only when signed_i). Clear the partial remainder; counter=0.
  - start_i=1 and b_i==0 -> ZERO; latch a_i.
  - start_i=0 -> stay in IDLE.
- BUSY, one iteration per edge:
  - Shift {rem, quo} left by 1.
  - Trial = rem_shifted - divisor (WIDTH+1 bits).
  - If trial is non-negative: rem = trial, quo[0] = 1; otherwise keep rem, quo[0] = 0.
  - counter++. On the edge where counter reaches WIDTH-1 (32nd iteration) -> DONE.
- ZERO: the next edge -> DONE with quotient = all ones and remainder = latched a_i, regardless of signed_i.
- DONE:
  - Leaving BUSY, result_o is loaded with sign-corrected values. Quotient is negated if its sign bit is set; remainder is negated if its sign bit is set.
  - ready_o=1 for exactly this one cycle; the next edge -> IDLE.
- Latency: start accepted at edge E0; iterations run on E1..E32; ready_o is high in the cycle after E32. Total 33 cycles, or 2 cycles for divide-by-zero.
- busy_o is combinational from state (BUSY|ZERO). It is 0 in DONE, so the stalled instruction advances in the same cycle it sees ready_o.
- result_o holds its last value until the next DONE. It is unchanged by annul and by new starts until completion.
- start_i in BUSY/ZERO/DONE is ignored. The pipeline holds start_i high while stalled; a new start is accepted only from IDLE.
- start_i and ready_o in the same cycle: DONE ignores start. The held instruction has already left E, so no double issue occurs.
- annul_i=1 in any state -> IDLE on the next edge. No ready_o pulse; result_o unchanged. Annul and start together in IDLE: stay in IDLE.
- Signed overflow 0x80000000 / 0xFFFFFFFF: magnitudes 2^31/1 give q = 0x80000000 (negation wraps) and r = 0. No trap.
- Width rules:
  - Magnitude of 0x80000000 is 0x80000000 interpreted as unsigned.
  - All subtraction is unsigned on WIDTH+1 bits.
  - Sign correction is two's-complement negation on WIDTH bits.

Decomposition:
- Shared package cpu_defs_pkg holds:
  - the state encoding constants DIV_IDLE, DIV_BUSY, DIV_ZERO, DIV_DONE;
  - the iteration count constant DIV_ITERS = 32.
- One sub-module is natural: div_signfix, a combinational block that computes the absolute value on input and the conditional negation on output, instantiated for the operands and the results.
- The state machine and datapath stay in div_unit.

Test Plan:
- Unsigned: DIVU, a=100, b=7, start held -> busy_o high for 32 cycles, ready_o in cycle 33, result_o = {0x00000002, 0x0000000E}.
- Signed: DIV, a=-7 (0xFFFFFFF9), b=2 -> q = 0xFFFFFFFD (-3), r = 0xFFFFFFFF (-1); repeat with a=7, b=-2 -> q = -3, r = 1.
- Overflow and zero:
  - DIV a=0x80000000, b=0xFFFFFFFF -> q = 0x80000000, r = 0.
  - DIVU a=0x12345678, b=0 -> ready_o in cycle 2, q = 0xFFFFFFFF, r = 0x12345678.
- Annul mid-operation: start, then pulse annul_i at iteration 10 -> IDLE next edge, no ready_o, result_o keeps the prior value. An immediate new start 1000/10 -> result {0, 100}, timed from its own accept edge.
- Reset mid-operation: deassert rst asynchronously (between edges) during BUSY -> busy_o, ready_o and result_o go to 0 immediately. After reset release, a fresh DIVU 9/3 -> {0, 3}.
- Back-to-back: start held through DONE, then a second divide issued -> exactly one ready_o per accepted start. A start seen in DONE is not accepted; the second divide is accepted only from IDLE.

Source files
------------

// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: divider state encoding and iteration count.
package cpu_defs_pkg;

  localparam int unsigned DIV_ITERS = 32;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_ZERO = 2'd2,
    DIV_DONE = 2'd3
  } divState_t;

endpackage

// File: rtl/div_signfix.sv
// Conditional two's-complement negation: operand magnitude on entry, sign correction on exit.
module div_signfix
  import cpu_defs_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_ITERS
) (
  input  logic [WIDTH-1:0] value,
  input  logic             negate,
  output logic [WIDTH-1:0] fixed_c
);

  assign fixed_c = negate ? ((~value) + WIDTH'(1)) : value;

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for MIPS DIV/DIVU; result is {remainder, quotient} for hi/lo.
module div_unit
  import cpu_defs_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_ITERS,
  parameter int unsigned CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               signed_i,
  input  logic               annul_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               busy_o,
  output logic               ready_o,
  output logic [2*WIDTH-1:0] result_o
);

  divState_t state, nextState;

  logic [WIDTH-1:0]   remR, quoR, divisorR;
  logic               qNegR, rNegR;
  logic [CNT_W-1:0]   cntR;
  logic               busyR, readyR;
  logic [2*WIDTH-1:0] resultR;

  logic               aNeg, bNeg;
  logic [WIDTH-1:0]   aMag, bMag;
  logic [WIDTH:0]     remShift, trial;
  logic [WIDTH-1:0]   remNext, quoNext, remFix, quoFix;
  logic               lastIter;

  assign aNeg = signed_i & a_i[WIDTH-1];
  assign bNeg = signed_i & b_i[WIDTH-1];

  div_signfix #(.WIDTH(WIDTH)) uAbsA (.value(a_i),     .negate(aNeg),  .fixed_c(aMag));
  div_signfix #(.WIDTH(WIDTH)) uAbsB (.value(b_i),     .negate(bNeg),  .fixed_c(bMag));
  div_signfix #(.WIDTH(WIDTH)) uFixQ (.value(quoNext), .negate(qNegR), .fixed_c(quoFix));
  div_signfix #(.WIDTH(WIDTH)) uFixR (.value(remNext), .negate(rNegR), .fixed_c(remFix));

  // One restoring step: the dividend shifts out of quo into rem as quotient bits shift in.
  assign remShift = {remR, quoR[WIDTH-1]};
  assign trial    = remShift - {1'b0, divisorR};
  assign quoNext  = {quoR[WIDTH-2:0], ~trial[WIDTH]};
  assign remNext  = trial[WIDTH] ? remShift[WIDTH-1:0] : trial[WIDTH-1:0];
  assign lastIter = (cntR == CNT_W'(WIDTH - 1));

  // Next-state logic; annul overrides everything.
  always_comb begin
    nextState = state;
    if (annul_i) begin
      nextState = DIV_IDLE;
    end else begin
      case (state)
        DIV_IDLE: if (start_i) nextState = (b_i == '0) ? DIV_ZERO : DIV_BUSY;
        DIV_BUSY: if (lastIter) nextState = DIV_DONE;
        DIV_ZERO: nextState = DIV_DONE;
        DIV_DONE: nextState = DIV_IDLE;
        default:  nextState = DIV_IDLE;
      endcase
    end
  end

  // State register; busy/ready are registered images of the state being entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= DIV_IDLE;
      busyR  <= 1'b0;
      readyR <= 1'b0;
    end else begin
      state  <= nextState;
      busyR  <= (nextState == DIV_BUSY) || (nextState == DIV_ZERO);
      readyR <= (nextState == DIV_DONE);
    end
  end

  // Datapath: operand capture, iteration, and result load on completion only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      remR     <= '0;
      quoR     <= '0;
      divisorR <= '0;
      qNegR    <= 1'b0;
      rNegR    <= 1'b0;
      cntR     <= '0;
      resultR  <= '0;
    end else if (!annul_i) begin
      case (state)
        DIV_IDLE: begin
          if (start_i) begin
            cntR <= '0;
            if (b_i == '0) begin
              remR <= a_i;
            end else begin
              remR     <= '0;
              quoR     <= aMag;
              divisorR <= bMag;
              qNegR    <= aNeg ^ bNeg;
              rNegR    <= aNeg;
            end
          end
        end
        DIV_BUSY: begin
          remR <= remNext;
          quoR <= quoNext;
          cntR <= cntR + CNT_W'(1);
          if (lastIter) resultR <= {remFix, quoFix};
        end
        DIV_ZERO: resultR <= {remR, {WIDTH{1'b1}}};
        default: ;
      endcase
    end
  end

  assign busy_o   = busyR;
  assign ready_o  = readyR;
  assign result_o = resultR;

endmodule
